// File: rtl/vram_bus_arbiter_pkg.sv
// vram_bus_arbiter_pkg: shared port indices, bus widths and round-robin helper
package vram_bus_arbiter_pkg;
  localparam int NUM_PORTS = 3;
  localparam logic [1:0] PORT_L0 = 2'd0;
  localparam logic [1:0] PORT_L1 = 2'd1;
  localparam logic [1:0] PORT_HOST = 2'd2;
  localparam int BUS_AW = 18;
  localparam int BUS_DW = 32;
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return p == PORT_HOST ? PORT_L0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: one-hot round-robin pick starting after the last winner
module rr_priority_select
  import vram_bus_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [1:0]           last,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 valid
);
  logic [1:0] p1, p2, p3;
  always_comb begin
    p1 = next_port(last);
    p2 = next_port(p1);
    p3 = next_port(p2);
    grant = eligible[p1] ? 3'b001 << p1 :
            eligible[p2] ? 3'b001 << p2 :
            eligible[p3] ? 3'b001 << p3 : 3'b000;
    valid = |eligible;
  end
endmodule

// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: round-robin arbiter giving two layer readers and a host one shared VRAM port
module vram_bus_arbiter
  import vram_bus_arbiter_pkg::*;
#(
  parameter int RAM_AW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS_AW-1:0]   l0_addr,
  input  logic                l0_strobe,
  output logic                l0_ack,
  input  logic [BUS_AW-1:0]   l1_addr,
  input  logic                l1_strobe,
  output logic                l1_ack,
  input  logic [BUS_AW-1:0]   host_addr,
  input  logic                host_strobe,
  input  logic                host_write,
  input  logic [BUS_DW-1:0]   host_wrdata,
  input  logic [3:0]          host_wrbytesel,
  output logic                host_ack,
  output logic [BUS_DW-1:0]   rddata,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic                ram_rden,
  output logic                ram_write,
  output logic [BUS_DW-1:0]   ram_wrdata,
  output logic [3:0]          ram_wrbytesel,
  input  logic [BUS_DW-1:0]   ram_rddata
);
  logic [NUM_PORTS-1:0] strobe, eligible, grant, s1_grant, ack;
  logic [1:0] last, win;
  logic [BUS_AW-1:0] win_addr;
  logic valid, win_write, unused;
  assign strobe = {host_strobe, l1_strobe, l0_strobe};
  // a port stays masked while its access is in the RAM stage or its ack stage
  assign eligible = strobe & ~(s1_grant | ack);
  rr_priority_select u_sel (
    .eligible(eligible),
    .last(last),
    .grant(grant),
    .valid(valid)
  );
  assign win = grant[PORT_L1] ? PORT_L1 : grant[PORT_HOST] ? PORT_HOST : PORT_L0;
  assign win_addr = grant[PORT_L1] ? l1_addr : grant[PORT_HOST] ? host_addr : l0_addr;
  assign win_write = grant[PORT_HOST] & host_write;
  assign unused = ^win_addr[1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_grant <= '0;
      ack <= '0;
      last <= PORT_HOST;
      ram_rden <= 1'b0;
      ram_write <= 1'b0;
      ram_addr <= '0;
      ram_wrdata <= '0;
      ram_wrbytesel <= '0;
    end else begin
      s1_grant <= grant;
      ack <= s1_grant;
      ram_rden <= valid & ~win_write;
      ram_write <= win_write;
      if (valid) begin
        last <= win;
        ram_addr <= win_addr[RAM_AW+1:2];
      end
      if (win_write) begin
        ram_wrdata <= host_wrdata;
        ram_wrbytesel <= host_wrbytesel;
      end
    end
  end
  assign l0_ack = ack[PORT_L0];
  assign l1_ack = ack[PORT_L1];
  assign host_ack = ack[PORT_HOST];
  assign rddata = ram_rddata;
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb_vram_bus_arbiter: directed and random requests checked against a cycle-number model
module tb_vram_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [17:0] l0_addr, l1_addr, host_addr;
  logic l0_strobe, l1_strobe, host_strobe, host_write;
  logic [31:0] host_wrdata = '0;
  logic [3:0] host_wrbytesel = '0;
  logic l0_ack, l1_ack, host_ack, ram_rden, ram_write;
  logic [31:0] rddata, ram_wrdata, ram_rddata;
  logic [31:0] rd_next = '0;
  logic [15:0] ram_addr;
  logic [3:0] ram_wrbytesel;

  vram_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .l0_addr(l0_addr), .l0_strobe(l0_strobe), .l0_ack(l0_ack),
    .l1_addr(l1_addr), .l1_strobe(l1_strobe), .l1_ack(l1_ack),
    .host_addr(host_addr), .host_strobe(host_strobe), .host_write(host_write),
    .host_wrdata(host_wrdata), .host_wrbytesel(host_wrbytesel), .host_ack(host_ack),
    .rddata(rddata), .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_write(ram_write),
    .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel), .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, last = 2;
  int ga[3] = '{-100, -100, -100};
  bit gw[3] = '{0, 0, 0};
  bit req[3] = '{0, 0, 0};
  bit eff[3] = '{0, 0, 0};
  int ack_cnt[3] = '{0, 0, 0};
  logic [17:0] addr[3] = '{18'h0, 18'h0, 18'h0};
  logic m_rden = 0, m_write = 0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wd = '0;
  logic [3:0] m_bs = '0;

  // a port granted at cycle g acks at g+2 and may win again from g+3
  function automatic bit m_ack(int p);
    return cyc == ga[p] + 2;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(bit r);
    int w;
    bit wr;
    w = -1;
    rst = r;
    for (int p = 0; p < 3; p++) eff[p] = req[p] && !m_ack(p);
    l0_strobe = eff[0]; l1_strobe = eff[1]; host_strobe = eff[2];
    l0_addr = addr[0]; l1_addr = addr[1]; host_addr = addr[2];
    if (!r)
      for (int k = 1; k <= 3; k++)
        if (w < 0 && eff[(last + k) % 3] && cyc >= ga[(last + k) % 3] + 3) w = (last + k) % 3;
    wr = (w == 2) && host_write;
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int p = 0; p < 3; p++) ga[p] = -100;
      last = 2; m_rden = 0; m_write = 0; m_addr = '0; m_wd = '0; m_bs = '0;
    end else begin
      m_rden = (w >= 0) && !wr;
      m_write = wr;
      if (w >= 0) begin
        ga[w] = cyc - 1; gw[w] = wr; last = w; m_addr = addr[w][17:2];
        if (wr) begin m_wd = host_wrdata; m_bs = host_wrbytesel; end
      end
    end
    ram_rddata = rd_next;
    rd_next = $urandom;
    #1;
    chk("ram_rden", ram_rden, m_rden);
    chk("ram_write", ram_write, m_write);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_wrdata", ram_wrdata, m_wd);
    chk("ram_wrbytesel", ram_wrbytesel, m_bs);
    chk("l0_ack", l0_ack, m_ack(0));
    chk("l1_ack", l1_ack, m_ack(1));
    chk("host_ack", host_ack, m_ack(2));
    for (int p = 0; p < 3; p++)
      if (m_ack(p) && !gw[p]) chk("rddata", rddata, ram_rddata);
    ack_cnt[0] += int'(l0_ack); ack_cnt[1] += int'(l1_ack); ack_cnt[2] += int'(host_ack);
    for (int p = 0; p < 3; p++) if (m_ack(p)) req[p] = 0;
  endtask

  initial begin
    host_write = 0;
    tick(1); tick(1);
    // single l0 read
    req[0] = 1; addr[0] = 18'h00040;
    tick(0);
    chk("r030_addr", ram_addr, 32'h0010);
    chk("r030_rden", ram_rden, 1);
    rd_next = 32'hDEADBEEF;
    tick(0);
    chk("r030_ack", l0_ack, 1);
    chk("r030_rddata", rddata, 32'hDEADBEEF);
    tick(0); tick(0); tick(0);
    // all three at once
    req = '{1, 1, 1}; addr = '{18'h00100, 18'h00200, 18'h00300};
    repeat (7) tick(0);
    // host write
    req[2] = 1; addr[2] = 18'h00008; host_write = 1;
    host_wrdata = 32'h11223344; host_wrbytesel = 4'b0101;
    tick(0);
    chk("r032_write", ram_write, 1);
    chk("r032_addr", ram_addr, 32'h0002);
    chk("r032_bsel", ram_wrbytesel, 32'h5);
    chk("r032_rden", ram_rden, 0);
    tick(0);
    chk("r032_ack", host_ack, 1);
    chk("r032_rden2", ram_rden, 0);
    host_write = 0;
    tick(0); tick(0);
    // l0 drops strobe after its grant
    req[0] = 1; addr[0] = 18'h01234;
    tick(0);
    req[0] = 0;
    tick(0);
    chk("r035_ack", l0_ack, 1);
    repeat (4) tick(0);
    // reset right after an l1 grant
    req[1] = 1; addr[1] = 18'h02220;
    tick(0);
    req = '{0, 0, 0};
    tick(1);
    chk("r034_rden", ram_rden, 0);
    chk("r034_addr", ram_addr, 0);
    req = '{1, 1, 0}; addr[0] = 18'h00400; addr[1] = 18'h00800;
    tick(0);
    chk("r034_l0_first", ram_addr, 32'h0100);
    repeat (5) tick(0);
    // l0/l1 continuous re-request
    ack_cnt = '{0, 0, 0};
    repeat (30) begin
      for (int p = 0; p < 2; p++) if (!req[p]) begin req[p] = 1; addr[p] = 18'($urandom); end
      tick(0);
    end
    chk("r033_fair", ((ack_cnt[0] - ack_cnt[1]) <= 1 && (ack_cnt[1] - ack_cnt[0]) <= 1), 1);
    chk("r033_progress", (ack_cnt[0] >= 8 && ack_cnt[1] >= 8), 1);
    req = '{0, 0, 0};
    repeat (4) tick(0);
    // random traffic with occasional reset
    repeat (400) begin
      for (int p = 0; p < 3; p++)
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p] = 1; addr[p] = 18'($urandom);
          if (p == 2) begin
            host_write = 1'($urandom); host_wrdata = $urandom; host_wrbytesel = 4'($urandom);
          end
        end
      if ($urandom_range(0, 49) == 0) begin
        req = '{0, 0, 0};
        tick(1);
      end else tick(0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
